// File: rtl/ordena_pkg.sv
// Shared types, sizes and the compare-exchange pair table of the 9-input sorter.
package ordena_pkg;

  localparam int WIDTH = 9;
  localparam int N     = 9;
  localparam int NCMP  = 25;

  typedef logic [WIDTH-1:0] word_t;

  // 25-comparator network, listed layer by layer; each pair is (lower index, higher index)
  localparam int CMP_LO [NCMP] = '{0, 1, 2, 4,  0, 2, 3, 5,  0, 1, 4, 7,  1, 3, 5,
                                   0, 2, 3, 6,  2, 4, 6,  1, 3, 5};
  localparam int CMP_HI [NCMP] = '{3, 7, 5, 8,  7, 4, 8, 6,  2, 3, 5, 8,  4, 6, 7,
                                   1, 4, 5, 8,  3, 5, 7,  2, 4, 6};

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange: smaller word on lo, larger word on hi (unsigned).
module cmp_swap #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic a_gt_b;

  assign a_gt_b = (a > b);
  assign lo     = a_gt_b ? b : a;
  assign hi     = a_gt_b ? a : b;

endmodule

// File: rtl/ordena_9_num_sync.sv
// Nine-word sorter: combinational compare-exchange network, order-select mux, one output register.
module ordena_9_num_sync #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cresc_ou_decres,
  input  logic [WIDTH-1:0] n1_n,
  input  logic [WIDTH-1:0] n2_n,
  input  logic [WIDTH-1:0] n3_n,
  input  logic [WIDTH-1:0] n4_n,
  input  logic [WIDTH-1:0] n5_n,
  input  logic [WIDTH-1:0] n6_n,
  input  logic [WIDTH-1:0] n7_n,
  input  logic [WIDTH-1:0] n8_n,
  input  logic [WIDTH-1:0] n9_n,
  output logic [WIDTH-1:0] n1,
  output logic [WIDTH-1:0] n2,
  output logic [WIDTH-1:0] n3,
  output logic [WIDTH-1:0] n4,
  output logic [WIDTH-1:0] n5,
  output logic [WIDTH-1:0] n6,
  output logic [WIDTH-1:0] n7,
  output logic [WIDTH-1:0] n8,
  output logic [WIDTH-1:0] n9
);

  import ordena_pkg::*;

  // net[k] is the word set seen by comparator k; net[NCMP] is fully ascending
  logic [WIDTH-1:0] net       [NCMP+1][N];
  logic [WIDTH-1:0] ordered   [N];
  logic [WIDTH-1:0] sorted_p0 [N];

  assign net[0][0] = n1_n;
  assign net[0][1] = n2_n;
  assign net[0][2] = n3_n;
  assign net[0][3] = n4_n;
  assign net[0][4] = n5_n;
  assign net[0][5] = n6_n;
  assign net[0][6] = n7_n;
  assign net[0][7] = n8_n;
  assign net[0][8] = n9_n;

  for (genvar k = 0; k < NCMP; k++) begin : g_cmp
    cmp_swap #(.W(WIDTH)) u_cmp (
      .a  (net[k][CMP_LO[k]]),
      .b  (net[k][CMP_HI[k]]),
      .lo (net[k+1][CMP_LO[k]]),
      .hi (net[k+1][CMP_HI[k]])
    );
    for (genvar j = 0; j < N; j++) begin : g_pass
      if (j != CMP_LO[k] && j != CMP_HI[k]) begin : g_wire
        assign net[k+1][j] = net[k][j];
      end
    end
  end

  // Descending order is the ascending result read back to front
  for (genvar i = 0; i < N; i++) begin : g_order
    assign ordered[i] = cresc_ou_decres ? net[NCMP][i] : net[NCMP][N-1-i];
  end

  // ---- stage p0: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sorted_p0[i] <= '0;
    end else if (ena) begin
      for (int i = 0; i < N; i++) sorted_p0[i] <= ordered[i];
    end
  end

  assign n1 = sorted_p0[0];
  assign n2 = sorted_p0[1];
  assign n3 = sorted_p0[2];
  assign n4 = sorted_p0[3];
  assign n5 = sorted_p0[4];
  assign n6 = sorted_p0[5];
  assign n7 = sorted_p0[6];
  assign n8 = sorted_p0[7];
  assign n9 = sorted_p0[8];

endmodule

// File: tb/tb_ordena_9_num_sync.sv
// Directed and randomized checks of the nine-word sorter against a queue-sort reference.
module tb_ordena_9_num_sync;

  typedef logic [8:0] vec_t [9];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cresc_ou_decres;
  logic [8:0] n1_n, n2_n, n3_n, n4_n, n5_n, n6_n, n7_n, n8_n, n9_n;
  logic [8:0] n1, n2, n3, n4, n5, n6, n7, n8, n9;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ordena_9_num_sync #(.WIDTH(9)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ena             (ena),
    .cresc_ou_decres (cresc_ou_decres),
    .n1_n (n1_n), .n2_n (n2_n), .n3_n (n3_n), .n4_n (n4_n), .n5_n (n5_n),
    .n6_n (n6_n), .n7_n (n7_n), .n8_n (n8_n), .n9_n (n9_n),
    .n1 (n1), .n2 (n2), .n3 (n3), .n4 (n4), .n5 (n5),
    .n6 (n6), .n7 (n7), .n8 (n8), .n9 (n9)
  );

  function automatic vec_t ref_sort(input vec_t v, input bit asc);
    logic [8:0] q [$];
    vec_t       o;
    for (int i = 0; i < 9; i++) q.push_back(v[i]);
    if (asc) q.sort();
    else     q.rsort();
    for (int i = 0; i < 9; i++) o[i] = q[i];
    return o;
  endfunction

  task automatic set_inputs(input vec_t v);
    n1_n = v[0]; n2_n = v[1]; n3_n = v[2]; n4_n = v[3]; n5_n = v[4];
    n6_n = v[5]; n7_n = v[6]; n8_n = v[7]; n9_n = v[8];
  endtask

  task automatic check(input string tag, input vec_t exp);
    vec_t got;
    got = '{n1, n2, n3, n4, n5, n6, n7, n8, n9};
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      assert (got[i] === exp[i]) else begin
        n_fail++;
        $error("FAIL %s n%0d: observed %0d expected %0d", tag, i + 1, got[i], exp[i]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t zeros, up, down, sevens, mixed, v, exp;
    zeros  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    up     = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    down   = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
    sevens = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
    mixed  = '{511, 0, 300, 1, 2, 3, 4, 5, 6};

    rst_n = 1'b0; ena = 1'b1; cresc_ou_decres = 1'b1;
    set_inputs(down);
    step();
    set_inputs(mixed);
    step();
    check("reset_hold", zeros);

    rst_n = 1'b1;
    v = '{5, 3, 8, 1, 9, 2, 7, 4, 6};
    set_inputs(v);
    step();
    check("first_capture", '{1, 2, 3, 4, 5, 6, 7, 8, 9});

    set_inputs(up);
    step();
    check("already_sorted", up);

    set_inputs(down);
    step();
    check("reversed_asc", up);
    cresc_ou_decres = 1'b0;
    step();
    check("reversed_desc", down);

    set_inputs(sevens);
    step();
    check("equal_desc", sevens);
    cresc_ou_decres = 1'b1;
    step();
    check("equal_asc", sevens);

    set_inputs(down);
    step();
    check("hold_load", up);
    ena = 1'b0;
    set_inputs(mixed);
    cresc_ou_decres = 1'b0;
    step();
    check("hold_1", up);
    step();
    check("hold_2", up);
    ena = 1'b1;
    cresc_ou_decres = 1'b1;
    step();
    check("hold_release", '{0, 1, 2, 3, 4, 5, 6, 300, 511});

    // asynchronous reset clears without a clock edge
    #1 rst_n = 1'b0;
    #1 check("async_clear", zeros);
    @(negedge clk);
    set_inputs(down);
    step();
    check("reset_wins", zeros);
    rst_n = 1'b1;
    step();
    check("after_reset", up);

    exp = up;
    for (int ord = 0; ord < 2; ord++) begin
      for (int t = 0; t < 1000; t++) begin
        for (int i = 0; i < 9; i++) begin
          case ($urandom_range(0, 3))
            0:       v[i] = 9'($urandom_range(0, 3));
            1:       v[i] = 9'd511;
            default: v[i] = 9'($urandom_range(0, 511));
          endcase
        end
        cresc_ou_decres = (ord == 0);
        ena = ($urandom_range(0, 7) != 0);
        set_inputs(v);
        if (ena) exp = ref_sort(v, cresc_ou_decres);
        step();
        check(ord == 0 ? "random_asc" : "random_desc", exp);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
